ep_issue_ctrl: RTL and testbench
================================

EP_ISSUE_CTRL -- requirements
Module: ep_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 7, meaning the even-pipe stage count tracked for hazards.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, a candidate instruction is present.
REQ-006 SHALL have port in_ready, output, 1, the candidate is accepted this cycle.
REQ-007 SHALL have port in_op, input, opcode, the candidate opcode (package enum).
REQ-008 SHALL have ports in_ra_addr, in_rb_addr and in_rc_addr, each input, 7, the source register addresses.
REQ-009 SHALL have port in_src_use, input, 3, source-used flags; bit0=ra, bit1=rb, bit2=rc.
REQ-010 SHALL have port in_rt_addr, input, 7, the destination register.
REQ-011 SHALL have port in_wr_en, input, 1, the candidate writes rt.
REQ-012 SHALL have port flush, input, 1, which kills all in-flight tracking.
REQ-013 SHALL have ports iss_valid, output, 1, and iss_op, output, opcode: the registered issue to the even pipe.
REQ-014 SHALL have ports iss_rt_addr, output, 7, and iss_wr_en, output, 1: the registered destination and write enable.
REQ-015 SHALL have port hazard, output, 1, combinational: the candidate is blocked by RAW.
REQ-016 SHALL have port stall_cnt, output, CNT_W, a saturating count of hazard-stall cycles.

Function
REQ-017 SHALL classify each op by latency: simple integer/logical/compare/immediate-load = 2; shift/rotate/byte (absolute differences, average, sum bytes, count ones) = 4; multiply and floating = 7.
REQ-018 SHALL keep a DEPTH-slot tracker with fields {valid, rt_addr, lat}; slot s holds the instruction accepted s cycles ago, s=1..DEPTH.
REQ-019 SHALL load slot 1 on acceptance only when in_wr_en=1; otherwise slot 1 is loaded invalid.
REQ-020 SHALL shift slots every cycle; slot DEPTH is discarded.
REQ-021 SHALL assert hazard when in_valid=1 and any valid slot s with s < slot.lat has rt_addr equal to a used source address; unused sources are ignored.
REQ-022 SHALL define in_ready = ~hazard & ~flush, and SHALL hold it high when in_valid=0.
REQ-023 SHALL register iss_* one cycle after acceptance; iss_valid=0 in any cycle following non-acceptance.
REQ-024 SHALL check a candidate whose rt equals its own source only against the tracker, never against itself.
REQ-025 SHALL keep a candidate blocked while any matching slot remains unresolved; multiple matches are blocked until the last one resolves.
REQ-026 SHALL apply flush=1 as follows: next edge invalidates all slots and clears iss_valid; the candidate is not accepted; stall_cnt is unchanged.
REQ-027 SHALL increment stall_cnt in every cycle with in_valid & hazard & ~flush, saturating at all-ones.
REQ-028 SHALL treat register address 0 as an ordinary register.

Reset
REQ-029 SHALL on reset asynchronously clear all slots, iss_valid, iss_op (to 0 encoding), iss_rt_addr, iss_wr_en and stall_cnt.
REQ-030 SHALL hold in_ready=0 while reset is asserted.
REQ-031 SHALL, after reset deasserts, accept the first instruction on the first rising edge.

Structure
REQ-032 SHALL place the latency constants LAT_SIMPLE=2, LAT_BYTE=4 and LAT_LONG=7, and a function mapping opcode to latency, in package descriptions beside the opcode enum.
REQ-033 SHALL place the tracker slot struct type in package descriptions.
REQ-034 SHALL use one sub-module, ep_hazard_tracker, holding the slot shift register and match logic; the top holds the handshake, the issue register and stall_cnt.

Verification
REQ-035 SHALL verify: ADD_WORD with rt=5, then back-to-back AND with ra=5 -> one stall cycle (hazard=1 for one cycle), AND issues 2 cycles after ADD; stall_cnt=1.
REQ-036 SHALL verify: MULTIPLY with rt=9, then OR with rb=9 -> 6 stall cycles; OR iss_valid 7 cycles after MULTIPLY; stall_cnt=6.
REQ-037 SHALL verify: ROTATE_WORD with rt=3, then NOR with ra=3 but in_src_use=3'b010 and rb=4 -> no stall, issue next cycle.
REQ-038 SHALL verify: FLOATING_MULTIPLY with rt=7, then the dependent op; assert flush on the cycle after -> dependent op accepted the cycle after flush, and tracker empty.
REQ-039 SHALL verify: reset asserted mid-stall with MULTIPLY in flight -> iss_valid=0 and stall_cnt=0 immediately; the dependent op issues 1 cycle after reset release.

Source files
------------

// File: rtl/descriptions.sv
// Opcode set, latency classes and tracker slot type shared by the even-pipe
// issue controller and its hazard tracker.
//   op_e        : candidate / issued opcode (OP_NOP is the all-zero encoding)
//   slot_t      : one in-flight tracker entry {valid, rt_addr, lat}
//   op_latency  : opcode -> result latency in cycles
package descriptions;

    localparam int REG_W = 7;
    localparam int LAT_W = 3;

    localparam logic [LAT_W-1:0] LAT_SIMPLE = 3'd2;
    localparam logic [LAT_W-1:0] LAT_BYTE   = 3'd4;
    localparam logic [LAT_W-1:0] LAT_LONG   = 3'd7;

    typedef enum logic [4:0] {
        OP_NOP               = 5'd0,
        OP_ADD_WORD          = 5'd1,
        OP_SUB_WORD          = 5'd2,
        OP_AND               = 5'd3,
        OP_OR                = 5'd4,
        OP_NOR               = 5'd5,
        OP_XOR               = 5'd6,
        OP_CMP_EQ            = 5'd7,
        OP_IMM_LOAD          = 5'd8,
        OP_SHIFT_LEFT        = 5'd9,
        OP_ROTATE_WORD       = 5'd10,
        OP_ABS_DIFF          = 5'd11,
        OP_AVG_BYTES         = 5'd12,
        OP_SUM_BYTES         = 5'd13,
        OP_COUNT_ONES        = 5'd14,
        OP_MULTIPLY          = 5'd15,
        OP_FLOATING_ADD      = 5'd16,
        OP_FLOATING_MULTIPLY = 5'd17
    } op_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rt_addr;
        logic [LAT_W-1:0] lat;
    } slot_t;

    function automatic logic [LAT_W-1:0] op_latency(input op_e op);
        case (op)
            OP_SHIFT_LEFT, OP_ROTATE_WORD, OP_ABS_DIFF,
            OP_AVG_BYTES, OP_SUM_BYTES, OP_COUNT_ONES:        op_latency = LAT_BYTE;
            OP_MULTIPLY, OP_FLOATING_ADD, OP_FLOATING_MULTIPLY: op_latency = LAT_LONG;
            default:                                          op_latency = LAT_SIMPLE;
        endcase
    endfunction

endpackage

// File: rtl/ep_hazard_tracker.sv
// Shift register of in-flight writers plus RAW match logic.
//   clock_i, reset_i : clock, async active-high reset
//   flush_i          : invalidate every slot on the next edge
//   load_i           : an accepted writer enters slot 1 (else slot 1 is a bubble)
//   load_rt_i/lat_i  : destination and latency of the accepted writer
//   ra/rb/rc_i       : candidate source addresses, src_use_i selects which count
//   hit_o            : some unresolved slot matches a used source
module ep_hazard_tracker
    import descriptions::*;
#(
    parameter int DEPTH = 7
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [REG_W-1:0] load_rt_i,
    input  logic [LAT_W-1:0] load_lat_i,
    input  logic [REG_W-1:0] ra_i,
    input  logic [REG_W-1:0] rb_i,
    input  logic [REG_W-1:0] rc_i,
    input  logic [2:0]       src_use_i,
    output logic             hit_o
);

    // slot_q[s] holds the instruction accepted s cycles ago
    slot_t slot_q [DEPTH:1];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 1; s <= DEPTH; s++) slot_q[s] <= '0;
        end else if (flush_i) begin
            for (int s = 1; s <= DEPTH; s++) slot_q[s] <= '0;
        end else begin
            slot_q[1] <= load_i ? slot_t'{valid: 1'b1, rt_addr: load_rt_i, lat: load_lat_i}
                                : '0;
            for (int s = 2; s <= DEPTH; s++) slot_q[s] <= slot_q[s-1];
        end
    end

    // A slot of age s is still unresolved while s < lat; its result is
    // usable by a candidate exactly lat cycles after acceptance.
    always_comb begin
        hit_o = 1'b0;
        for (int s = 1; s <= DEPTH; s++) begin
            if (slot_q[s].valid && (s < int'(slot_q[s].lat))) begin
                if ((src_use_i[0] && (slot_q[s].rt_addr == ra_i)) ||
                    (src_use_i[1] && (slot_q[s].rt_addr == rb_i)) ||
                    (src_use_i[2] && (slot_q[s].rt_addr == rc_i))) begin
                    hit_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ep_issue_ctrl.sv
// Even-pipe issue controller: accepts a candidate when no RAW hazard is
// pending, registers the issue, and counts hazard-stall cycles.
//   clock, reset        : clock, async active-high reset
//   in_valid / in_ready : candidate present / accepted this cycle
//                         (accept = in_valid & in_ready; in_ready does not
//                         depend on in_valid being low)
//   in_op, in_*_addr    : candidate opcode, sources, destination
//   in_src_use, in_wr_en: used-source flags {rc,rb,ra}, writes rt
//   flush               : drop all tracking and the pending issue
//   iss_*               : registered issue, one cycle after acceptance
//   hazard              : combinational RAW block of the current candidate
//   stall_cnt           : saturating hazard-stall cycle count
module ep_issue_ctrl
    import descriptions::*;
#(
    parameter int DEPTH = 7,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              in_op,
    input  logic [REG_W-1:0] in_ra_addr,
    input  logic [REG_W-1:0] in_rb_addr,
    input  logic [REG_W-1:0] in_rc_addr,
    input  logic [2:0]       in_src_use,
    input  logic [REG_W-1:0] in_rt_addr,
    input  logic             in_wr_en,
    input  logic             flush,
    output logic             iss_valid,
    output op_e              iss_op,
    output logic [REG_W-1:0] iss_rt_addr,
    output logic             iss_wr_en,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_cnt
);

    logic hit;
    logic accept;

    logic             iss_valid_q, iss_valid_d;
    op_e              iss_op_q, iss_op_d;
    logic [REG_W-1:0] iss_rt_q, iss_rt_d;
    logic             iss_wr_q, iss_wr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    ep_hazard_tracker #(.DEPTH(DEPTH)) u_tracker (
        .clock_i    (clock),
        .reset_i    (reset),
        .flush_i    (flush),
        .load_i     (accept & in_wr_en),
        .load_rt_i  (in_rt_addr),
        .load_lat_i (op_latency(in_op)),
        .ra_i       (in_ra_addr),
        .rb_i       (in_rb_addr),
        .rc_i       (in_rc_addr),
        .src_use_i  (in_src_use),
        .hit_o      (hit)
    );

    // The candidate is never compared with itself: the tracker only holds
    // already-accepted instructions.
    assign hazard   = in_valid & hit;
    assign in_ready = ~hazard & ~flush & ~reset;
    assign accept   = in_valid & in_ready;

    always_comb begin
        iss_valid_d = accept;
        iss_op_d    = accept ? in_op      : iss_op_q;
        iss_rt_d    = accept ? in_rt_addr : iss_rt_q;
        iss_wr_d    = accept ? in_wr_en   : iss_wr_q;
        stall_cnt_d = stall_cnt_q;
        if (in_valid && hazard && !flush && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iss_valid_q <= 1'b0;
            iss_op_q    <= OP_NOP;
            iss_rt_q    <= '0;
            iss_wr_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_rt_q    <= iss_rt_d;
            iss_wr_q    <= iss_wr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_op      = iss_op_q;
    assign iss_rt_addr = iss_rt_q;
    assign iss_wr_en   = iss_wr_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ep_issue_ctrl.sv
module tb_ep_issue_ctrl;
    import descriptions::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        in_valid = 1'b0;
    logic        in_ready;
    op_e         in_op = OP_NOP;
    logic [6:0]  in_ra_addr = '0, in_rb_addr = '0, in_rc_addr = '0, in_rt_addr = '0;
    logic [2:0]  in_src_use = '0;
    logic        in_wr_en = 1'b0;
    logic        flush = 1'b0;
    logic        iss_valid;
    op_e         iss_op;
    logic [6:0]  iss_rt_addr;
    logic        iss_wr_en;
    logic        hazard;
    logic [15:0] stall_cnt;

    ep_issue_ctrl #(.DEPTH(7), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
        .in_src_use(in_src_use), .in_rt_addr(in_rt_addr), .in_wr_en(in_wr_en),
        .flush(flush),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_rt_addr(iss_rt_addr),
        .iss_wr_en(iss_wr_en), .hazard(hazard), .stall_cnt(stall_cnt)
    );

    int n_checks = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Each register is free from the cycle its last writer's result is ready.
    function automatic int exp_lat(input op_e op);
        if (op inside {OP_MULTIPLY, OP_FLOATING_ADD, OP_FLOATING_MULTIPLY}) return 7;
        if (op inside {OP_SHIFT_LEFT, OP_ROTATE_WORD, OP_ABS_DIFF,
                       OP_AVG_BYTES, OP_SUM_BYTES, OP_COUNT_ONES}) return 4;
        return 2;
    endfunction

    int         cyc = 0;
    int         m_ready [128];
    logic       m_iss_valid = 1'b0;
    op_e        m_iss_op = OP_NOP;
    logic [6:0] m_iss_rt = '0;
    logic       m_iss_wr = 1'b0;
    int         m_stall = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic m_blocked();
        return in_valid && ((in_src_use[0] && cyc < m_ready[in_ra_addr]) ||
                            (in_src_use[1] && cyc < m_ready[in_rb_addr]) ||
                            (in_src_use[2] && cyc < m_ready[in_rc_addr]));
    endfunction

    function automatic logic m_ready_out();
        return !reset && !flush && !m_blocked();
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_iss_valid <= 1'b0;
            m_iss_op    <= OP_NOP;
            m_iss_rt    <= '0;
            m_iss_wr    <= 1'b0;
            m_stall     <= 0;
            for (int r = 0; r < 128; r++) m_ready[r] <= 0;
        end else if (flush) begin
            m_iss_valid <= 1'b0;
            for (int r = 0; r < 128; r++) m_ready[r] <= 0;
        end else begin
            m_iss_valid <= in_valid && m_ready_out();
            if (in_valid && m_ready_out()) begin
                m_iss_op <= in_op;
                m_iss_rt <= in_rt_addr;
                m_iss_wr <= in_wr_en;
                if (in_wr_en && (cyc + exp_lat(in_op) > m_ready[in_rt_addr]))
                    m_ready[in_rt_addr] <= cyc + exp_lat(in_op);
            end
            if (m_blocked() && m_stall < 65535) m_stall <= m_stall + 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        chk("hazard", 32'(hazard), 32'(m_blocked()));
        chk("in_ready", 32'(in_ready), 32'(m_ready_out()));
        chk("iss_valid", 32'(iss_valid), 32'(m_iss_valid));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (m_iss_valid) begin
            chk("iss_op", 32'(iss_op), 32'(m_iss_op));
            chk("iss_rt_addr", 32'(iss_rt_addr), 32'(m_iss_rt));
            chk("iss_wr_en", 32'(iss_wr_en), 32'(m_iss_wr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input op_e op, input logic [6:0] ra, input logic [6:0] rb,
                         input logic [6:0] rc, input logic [2:0] su, input logic [6:0] rt,
                         input logic wr, input logic fl);
        in_valid = v; in_op = op; in_ra_addr = ra; in_rb_addr = rb; in_rc_addr = rc;
        in_src_use = su; in_rt_addr = rt; in_wr_en = wr; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, OP_NOP, 7'd0, 7'd0, 7'd0, 3'b000, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        #1;
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_iss_op", 32'(iss_op), 32'd0);
        chk("rst_iss_rt", 32'(iss_rt_addr), 32'd0);
        chk("rst_iss_wr", 32'(iss_wr_en), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Hold the current candidate until it is accepted; returns hazard cycles.
    task automatic wait_accept(input string nm, output int stalls);
        stalls = 0;
        @(negedge clock);
        while (in_ready !== 1'b1 && stalls < 20) begin
            chk({nm, "_hazard"}, 32'(hazard), 32'd1);
            stalls++;
            next_cycle();
            @(negedge clock);
        end
    endtask

    // Writer for one cycle, then a dependent candidate; check stall count and issue.
    task automatic run_pair(input string nm, input op_e op1, input logic [6:0] rt1, input logic wr1,
                            input op_e op2, input logic [6:0] ra2, input logic [6:0] rb2,
                            input logic [2:0] su2, input int exp_stall);
        int stalls;
        apply_reset();
        drive(1'b1, op1, 7'd0, 7'd0, 7'd0, 3'b000, rt1, wr1, 1'b0);
        @(negedge clock);
        chk({nm, "_first_ready"}, 32'(in_ready), 32'd1);
        next_cycle();
        drive(1'b1, op2, ra2, rb2, 7'd0, su2, 7'd20, 1'b1, 1'b0);
        wait_accept(nm, stalls);
        chk({nm, "_stalls"}, 32'(stalls), 32'(exp_stall));
        next_cycle();
        idle();
        @(negedge clock);
        chk({nm, "_iss_valid"}, 32'(iss_valid), 32'd1);
        chk({nm, "_iss_op"}, 32'(iss_op), 32'(op2));
        chk({nm, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        next_cycle();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int stalls;
        apply_reset();

        run_pair("add_and",  OP_ADD_WORD,    7'd5,  1'b1, OP_AND, 7'd5,  7'd0, 3'b001, 1);
        run_pair("mul_or",   OP_MULTIPLY,    7'd9,  1'b1, OP_OR,  7'd0,  7'd9, 3'b010, 6);
        run_pair("rot_nor",  OP_ROTATE_WORD, 7'd3,  1'b1, OP_NOR, 7'd3,  7'd4, 3'b010, 0);
        run_pair("shl_xor",  OP_SHIFT_LEFT,  7'd11, 1'b1, OP_XOR, 7'd0,  7'd11, 3'b010, 3);
        run_pair("reg0",     OP_ADD_WORD,    7'd0,  1'b1, OP_AND, 7'd0,  7'd0, 3'b001, 1);
        run_pair("no_wr",    OP_MULTIPLY,    7'd5,  1'b0, OP_AND, 7'd5,  7'd0, 3'b001, 0);
        run_pair("self_src", OP_XOR,         7'd10, 1'b1, OP_AND, 7'd20, 7'd0, 3'b001, 0);

        // two pending writers matched: blocked until the later-resolving MUL (cycle 7)
        apply_reset();
        drive(1'b1, OP_MULTIPLY, 7'd0, 7'd0, 7'd0, 3'b000, 7'd9, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, OP_ADD_WORD, 7'd0, 7'd0, 7'd0, 3'b000, 7'd8, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, OP_OR, 7'd9, 7'd8, 7'd0, 3'b011, 7'd20, 1'b1, 1'b0);
        wait_accept("multi", stalls);
        chk("multi_stalls", 32'(stalls), 32'd5);
        next_cycle();
        idle();
        @(negedge clock);
        chk("multi_stall_cnt", 32'(stall_cnt), 32'd5);
        next_cycle();

        // flush while the dependent op is blocked
        apply_reset();
        drive(1'b1, OP_FLOATING_MULTIPLY, 7'd0, 7'd0, 7'd0, 3'b000, 7'd7, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, OP_ADD_WORD, 7'd7, 7'd0, 7'd0, 3'b001, 7'd21, 1'b1, 1'b1);
        @(negedge clock);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_prev_issue", 32'(iss_op), 32'(OP_FLOATING_MULTIPLY));
        next_cycle();
        flush = 1'b0;
        @(negedge clock);
        chk("flush_after_ready", 32'(in_ready), 32'd1);
        chk("flush_after_hazard", 32'(hazard), 32'd0);
        chk("flush_iss_cleared", 32'(iss_valid), 32'd0);
        chk("flush_stall_cnt", 32'(stall_cnt), 32'd0);
        next_cycle();
        idle();
        @(negedge clock);
        chk("flush_dep_issue", 32'(iss_valid), 32'd1);
        chk("flush_dep_rt", 32'(iss_rt_addr), 32'd21);
        next_cycle();

        // reset in the middle of a MULTIPLY stall
        apply_reset();
        drive(1'b1, OP_MULTIPLY, 7'd0, 7'd0, 7'd0, 3'b000, 7'd9, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, OP_OR, 7'd0, 7'd9, 7'd0, 3'b010, 7'd22, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        #2 reset = 1'b1;
        #1;
        chk("midrst_iss_valid", 32'(iss_valid), 32'd0);
        chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("postrst_ready", 32'(in_ready), 32'd1);
        next_cycle();
        idle();
        @(negedge clock);
        chk("postrst_issue", 32'(iss_valid), 32'd1);
        chk("postrst_op", 32'(iss_op), 32'(OP_OR));
        next_cycle();

        // mixed stream on a small register set, checked by the model each cycle
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), op_e'(5'($urandom_range(0, 17))),
                  7'($urandom_range(0, 3)), 7'($urandom_range(0, 3)), 7'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 7'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            next_cycle();
        end
        idle();
        repeat (3) next_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
